// File: rtl/dif_arbiter_pkg.sv
// rtl/dif_arbiter_pkg.sv - shared types, defaults and helpers for the subtract arbiter
package dif_arbiter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF  = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

    // Lowest bit of requester idx's operand in the flat req_a/req_b buses.
    function automatic int op_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dif_w.sv
// rtl/dif_w.sv - combinational WIDTH-bit subtractor with unsigned borrow
module dif_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rez,
    output logic             borrow
);

    // The extra top bit of the widened difference is the borrow out.
    assign {borrow, rez} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/dif_arbiter.sv
// rtl/dif_arbiter.sv - round-robin arbiter sharing one subtractor across requesters
module dif_arbiter
    import dif_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_borrow,
    output logic [IDW-1:0]        res_id
);

    slot_e                slot_q;
    slot_e                slot_d;
    logic [IDW-1:0]       rr_ptr;
    logic [2*NREQ-1:0]    doubled;
    logic [NREQ-1:0]      rotated;
    logic [IDW-1:0]       offset;
    logic [IDW-1:0]       grant_id;
    logic                 found;
    logic                 slot_free;
    logic                 grant;
    logic [WIDTH-1:0]     a_arr [NREQ];
    logic [WIDTH-1:0]     b_arr [NREQ];
    logic [WIDTH-1:0]     dif_rez;
    logic                 dif_borrow;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[op_lsb(i, WIDTH) +: WIDTH];
        assign b_arr[i] = req_b[op_lsb(i, WIDTH) +: WIDTH];
    end

    assign res_valid = (slot_q == SLOT_FULL);
    assign slot_free = !res_valid || res_ready;

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate back.
    assign doubled = {req_valid, req_valid} >> rr_ptr;
    assign rotated = doubled[NREQ-1:0];

    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = IDW'(i);
        end
    end

    assign found     = |rotated;
    assign grant_id  = rr_ptr + offset;
    assign grant     = found && slot_free && !rst;
    assign req_ready = grant ? (NREQ'(1) << grant_id) : '0;

    dif_w #(.WIDTH(WIDTH)) u_dif_w (
        .a      (a_arr[grant_id]),
        .b      (b_arr[grant_id]),
        .rez    (dif_rez),
        .borrow (dif_borrow)
    );

    always_comb begin
        slot_d = slot_q;
        if (grant) begin
            slot_d = SLOT_FULL;
        end else if (res_ready) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Result fields only move on a grant; a plain drain leaves them holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data   <= '0;
            res_borrow <= 1'b0;
            res_id     <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            res_data   <= dif_rez;
            res_borrow <= dif_borrow;
            res_id     <= grant_id;
            rr_ptr     <= grant_id + IDW'(1);
        end
    end

endmodule

// File: tb/tb_dif_arbiter.sv
// tb/tb_dif_arbiter.sv - randomized and directed bench for dif_arbiter
module tb_dif_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_borrow;
    logic [IW-1:0]  res_id;

    dif_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_borrow (res_borrow),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending requests, pointer and the result slot.
    bit  mv [N];
    int  ma [N];
    int  mb [N];
    int  m_ptr = 0;
    int  m_g = -1;
    bit  m_rv = 1'b0;
    bit  m_bor = 1'b0;
    int  m_data = 0;
    int  m_id = 0;
    bit  m_rr = 1'b0;
    bit  m_rst = 1'b0;

    logic [N-1:0]      exp_ready;
    logic [W+IW+1:0]   exp_out;
    logic [W+IW+1:0]   got_out;

    task automatic apply(input bit rr, input bit r);
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = mv[i];
            req_a[i*W +: W]  = W'(ma[i]);
            req_b[i*W +: W]  = W'(mb[i]);
        end
        res_ready = rr;
        rst       = r;
        m_rr      = rr;
        m_rst     = r;
        m_g       = -1;
        if (!r && (!m_rv || rr)) begin
            for (int k = 0; k < N; k++) begin
                if (m_g < 0 && mv[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (m_g >= 0) exp_ready[m_g] = 1'b1;
        #1;
    endtask

    task automatic clock();
        @(posedge clk);
        if (m_rst) begin
            m_rv = 1'b0; m_data = 0; m_bor = 1'b0; m_id = 0; m_ptr = 0;
        end else if (m_g >= 0) begin
            m_data = (ma[m_g] - mb[m_g] + 256) % 256;
            m_bor  = (ma[m_g] < mb[m_g]);
            m_id   = m_g;
            m_rv   = 1'b1;
            m_ptr  = (m_g + 1) % N;
            mv[m_g] = 1'b0;
        end else if (m_rr) begin
            m_rv = 1'b0;
        end
        exp_out = {m_rv, W'(m_data), m_bor, IW'(m_id)};
        #1;
        got_out = {res_valid, res_data, res_borrow, res_id};
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; ma[i] = 0; mb[i] = 0;
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, c < 2);
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL reset_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out || got_out !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d got %h expected %h", c, got_out, exp_out);
            end
        end
    endtask

    task automatic test_single();
        clear_reqs();
        mv[0] = 1'b1; ma[0] = 'h10; mb[0] = 'h03;
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b0);
            vectors++;
            if (req_ready !== exp_ready || (c == 0 && req_ready !== 4'b0001)) begin
                miscompares++;
                $display("FAIL single_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out) begin
                miscompares++;
                $display("FAIL single_out cycle %0d got %h expected %h", c, got_out, exp_out);
            end
            if (c == 0) begin
                vectors++;
                if (res_valid !== 1'b1 || res_data !== 8'h0D || res_borrow !== 1'b0 || res_id !== 2'd0) begin
                    miscompares++;
                    $display("FAIL single_value got v=%b d=%h b=%b id=%0d expected v=1 d=0d b=0 id=0",
                             res_valid, res_data, res_borrow, res_id);
                end
            end
        end
    endtask

    task automatic test_borrow();
        logic [W+IW:0] want [2];
        want[0] = {8'hFF, 1'b1, 2'd2};
        want[1] = {8'h00, 1'b0, 2'd2};
        clear_reqs();
        for (int c = 0; c < 2; c++) begin
            mv[2] = 1'b1;
            ma[2] = (c == 0) ? 'h00 : 'h55;
            mb[2] = (c == 0) ? 'h01 : 'h55;
            apply(1'b1, 1'b0);
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL borrow_ready case %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out || got_out[W+IW:0] !== want[c]) begin
                miscompares++;
                $display("FAIL borrow_out case %0d got %h expected %h", c, got_out, exp_out);
            end
        end
    endtask

    task automatic test_round_robin();
        clear_reqs();
        apply(1'b1, 1'b1);
        clock();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i]) begin
                    mv[i] = 1'b1; ma[i] = $urandom_range(255); mb[i] = $urandom_range(255);
                end
            end
            apply(1'b1, 1'b0);
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rr_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out || res_valid !== 1'b1 || int'(res_id) != c % N) begin
                miscompares++;
                $display("FAIL rr_out cycle %0d got %h expected %h id %0d", c, got_out, exp_out, c % N);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_reqs();
        apply(1'b1, 1'b1);
        clock();
        mv[1] = 1'b1; ma[1] = 'h30; mb[1] = 'h10;
        apply(1'b1, 1'b0);
        clock();
        mv[3] = 1'b1; ma[3] = 'h07; mb[3] = 'h09;
        for (int c = 0; c < 5; c++) begin
            apply(c >= 3, 1'b0);
            vectors++;
            if (req_ready !== exp_ready || (c < 3 && req_ready !== 4'b0000) || (c == 3 && req_ready !== 4'b1000)) begin
                miscompares++;
                $display("FAIL bp_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out || (c < 2 && {res_data, res_id} !== {8'h20, 2'd1})) begin
                miscompares++;
                $display("FAIL bp_out cycle %0d got %h expected %h", c, got_out, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_reqs();
        apply(1'b1, 1'b1);
        clock();
        mv[1] = 1'b1; ma[1] = 'h44; mb[1] = 'h04;
        apply(1'b0, 1'b0);
        clock();
        mv[1] = 1'b1; ma[1] = 'h12; mb[1] = 'h34;
        mv[3] = 1'b1; ma[3] = 'h80; mb[3] = 'h01;
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, c == 0);
            vectors++;
            if (req_ready !== exp_ready || (c == 1 && req_ready !== 4'b0010)) begin
                miscompares++;
                $display("FAIL rstmid_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out || (c == 0 && res_valid !== 1'b0)) begin
                miscompares++;
                $display("FAIL rstmid_out cycle %0d got %h expected %h", c, got_out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        bit rr;
        bit r;
        int pick;
        clear_reqs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(1) == 1) begin
                    mv[i] = 1'b1;
                    pick = $urandom_range(3);
                    ma[i] = (pick == 0) ? 0 : $urandom_range(255);
                    mb[i] = (pick == 1) ? ma[i] : (pick == 2) ? 255 : $urandom_range(255);
                end
            end
            rr = ($urandom_range(3) != 0);
            r  = ($urandom_range(63) == 0);
            apply(rr, r);
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL random_ready cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            clock();
            vectors++;
            if (got_out !== exp_out) begin
                miscompares++;
                $display("FAIL random_out cycle %0d got %h expected %h", c, got_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_borrow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
